// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage -- writeback end of the integer pipeline.
//
// Registers the MEM/WB boundary, waits for load data from data memory when it
// is not already available, aligns and sign/zero-extends loaded bytes and
// halves, selects the writeback source (ALU result, load data, PC+4) and
// drives the register-file write port plus a bypass copy for operand
// forwarding.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   mem_valid/mem_ready MEM->WB handshake; mem_ready is low while a load waits
//   alu_result, pc_out  ALU result (also the load byte address) and PC
//   rd_addr, reg_wr     destination register and its write enable
//   wb_sel              00 ALU, 01 load, 10 PC+4, 11 treated as ALU
//   ld_funct3           load size/sign (LB, LH, LW, LBU, LHU)
//   dmem_rdata/rvalid   raw load word and its valid strobe
//   flush               kills the instruction captured or pending here
//   rf_wr_en/waddr/wdata register-file write port (one-cycle write pulse)
//   fwd_valid           bypass qualifier, identical to rf_wr_en
//
// Optional feature, macro WB_INSTRET_EN: adds a 64-bit retired-instruction
// counter (output instret) with a synchronous clear (input instret_clr).
// ---------------------------------------------------------------------------
module wb_stage #(
  parameter int XLEN      = 32,
  parameter int RF_ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic [XLEN-1:0]      alu_result,
  input  logic [XLEN-1:0]      pc_out,
  input  logic [RF_ADDR_W-1:0] rd_addr,
  input  logic                 reg_wr,
  input  logic [1:0]           wb_sel,
  input  logic [2:0]           ld_funct3,
  input  logic [XLEN-1:0]      dmem_rdata,
  input  logic                 dmem_rvalid,
  input  logic                 flush,
  output logic                 rf_wr_en,
  output logic [RF_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]      rf_wdata,
  output logic                 fwd_valid
`ifdef WB_INSTRET_EN
  ,
  input  logic                 instret_clr,
  output logic [63:0]          instret
`endif
);

  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  state_t                 state;
  logic [1:0]             lane_q;
  logic [2:0]             funct3_q;
  logic [RF_ADDR_W-1:0]   rd_q;
  logic                   reg_wr_q;

  logic                   accept;
  logic                   is_load;
  logic [XLEN-1:0]        sel_value;

  // Extract the addressed byte/half from the raw word and extend it.
  // Undefined funct3 encodings pass the word through untouched.
  function automatic logic [XLEN-1:0] align_load(input logic [XLEN-1:0] word,
                                                 input logic [1:0]      lane,
                                                 input logic [2:0]      f3);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'b0, b};
      3'b101:  r = {16'b0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Writeback source selection for an instruction retiring straight out of
  // IDLE; reserved wb_sel=11 falls back to the ALU result.
  always_comb begin
    accept  = mem_valid & mem_ready;
    is_load = (wb_sel == 2'b01);
    case (wb_sel)
      2'b01:   sel_value = align_load(dmem_rdata, alu_result[1:0], ld_funct3);
      2'b10:   sel_value = pc_out + XLEN'(4);
      default: sel_value = alu_result;
    endcase
  end

  // Control FSM and registered write port. A load whose data is not yet
  // available parks in WAIT_LOAD with only the fields needed to finish it.
  // flush beats a same-cycle dmem_rvalid and never produces a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_ready <= 1'b1;
      rf_wr_en  <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      lane_q    <= '0;
      funct3_q  <= '0;
      rd_q      <= '0;
      reg_wr_q  <= 1'b0;
    end else begin
      rf_wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && !flush) begin
            if (is_load && !dmem_rvalid) begin
              state     <= WAIT_LOAD;
              mem_ready <= 1'b0;
              lane_q    <= alu_result[1:0];
              funct3_q  <= ld_funct3;
              rd_q      <= rd_addr;
              reg_wr_q  <= reg_wr;
            end else begin
              rf_wr_en <= reg_wr & (rd_addr != '0);
              rf_waddr <= rd_addr;
              rf_wdata <= sel_value;
            end
          end
        end
        WAIT_LOAD: begin
          if (flush) begin
            state     <= IDLE;
            mem_ready <= 1'b1;
          end else if (dmem_rvalid) begin
            state     <= IDLE;
            mem_ready <= 1'b1;
            rf_wr_en  <= reg_wr_q & (rd_q != '0);
            rf_waddr  <= rd_q;
            rf_wdata  <= align_load(dmem_rdata, lane_q, funct3_q);
          end
        end
        default: begin
          state     <= IDLE;
          mem_ready <= 1'b1;
        end
      endcase
    end
  end

  assign fwd_valid = rf_wr_en;

`ifdef WB_INSTRET_EN
  logic retire;

  // An instruction retires when it leaves the stage unflushed, whether or
  // not it actually writes the register file.
  always_comb begin
    retire = (accept && !flush && (!is_load || dmem_rvalid)) ||
             (state == WAIT_LOAD && !flush && dmem_rvalid);
  end

  // Retired-instruction counter; clear wins over a same-cycle retirement.
  always_ff @(posedge clk) begin
    if (rst)              instret <= '0;
    else if (instret_clr) instret <= '0;
    else if (retire)      instret <= instret + 64'd1;
  end
`endif

endmodule
